// File: rtl/product_accumulate_module.sv
// Sums N_SAMPLES consecutive signed products into a saturating accumulator and
// presents each batch sum with a done/acknowledge handshake.
module product_accumulate_module #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 20
) (
    input  logic                    CLK,
    input  logic                    RSTn,
    input  logic                    Clear_Sig,
    input  logic signed [15:0]      Product,
    input  logic                    Product_Valid,
    input  logic                    Ack_Sig,
    output logic signed [ACC_W-1:0] Sum,
    output logic                    Done_Sig,
    output logic                    Sat_Sig,
    output logic                    Overrun_Sig,
    output logic [7:0]              Count,
    output logic                    dbg_state
);

    // Handshake: Product is consumed on every rising edge with Product_Valid=1,
    // except in DONE without Ack_Sig, where it is dropped and flagged as overrun.
    // Sum/Sat_Sig are held stable while Done_Sig=1; Ack_Sig=1 releases them.
    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_DONE  = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [7:0]              LAST_CNT = 8'(N_SAMPLES - 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    sat_run_q, sat_run_d;
    logic signed [ACC_W-1:0] sum_q, sum_d;
    logic                    sat_q, sat_d;
    logic                    ovr_q, ovr_d;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W:0]   sum_wide;
    logic signed [ACC_W-1:0] sum_clamped;
    logic                    clamp;

    // One extra bit of headroom: overflow shows up as the top two bits differing.
    always_comb begin
        prod_ext    = {{(ACC_W-16){Product[15]}}, Product};
        sum_wide    = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        clamp       = sum_wide[ACC_W] != sum_wide[ACC_W-1];
        sum_clamped = sum_wide[ACC_W-1:0];
        if (clamp) begin
            sum_clamped = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_run_d = sat_run_q;
        sum_d     = sum_q;
        sat_d     = sat_q;
        ovr_d     = ovr_q;

        if (Clear_Sig) begin
            state_d   = ST_ACCUM;
            acc_d     = '0;
            cnt_d     = '0;
            sat_run_d = 1'b0;
            sum_d     = '0;
            sat_d     = 1'b0;
            ovr_d     = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (Product_Valid) begin
                        if (cnt_q == LAST_CNT) begin
                            sum_d     = sum_clamped;
                            sat_d     = sat_run_q | clamp;
                            acc_d     = '0;
                            cnt_d     = '0;
                            sat_run_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            acc_d     = sum_clamped;
                            cnt_d     = cnt_q + 8'd1;
                            sat_run_d = sat_run_q | clamp;
                        end
                    end
                end
                ST_DONE: begin
                    if (Ack_Sig) begin
                        state_d = ST_ACCUM;
                        // A product on the acknowledging edge opens the next batch.
                        if (Product_Valid) begin
                            acc_d = prod_ext;
                            cnt_d = 8'd1;
                        end
                    end else if (Product_Valid) begin
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= ST_ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_run_q <= 1'b0;
            sum_q     <= '0;
            sat_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_run_q <= sat_run_d;
            sum_q     <= sum_d;
            sat_q     <= sat_d;
            ovr_q     <= ovr_d;
        end
    end

    assign Sum         = sum_q;
    assign Done_Sig    = (state_q == ST_DONE);
    assign Sat_Sig     = sat_q;
    assign Overrun_Sig = ovr_q;
    assign Count       = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_product_accumulate_module.sv
// Drives one stimulus stream into a 20-bit and a 17-bit accumulator; a monitor
// checks each reported batch against hand-computed sums queued per instance.
module tb_product_accumulate_module;

    logic               CLK;
    logic               RSTn;
    logic               Clear_Sig;
    logic signed [15:0] Product;
    logic               Product_Valid;
    logic               Ack_Sig;

    logic [19:0] sum20;
    logic        done20, sat20, ovr20, dbg20;
    logic [7:0]  cnt20;
    logic [16:0] sum17;
    logic        done17, sat17, ovr17, dbg17;
    logic [7:0]  cnt17;

    int checks = 0;
    int errors = 0;

    logic [20:0] exp20_q[$];
    logic [17:0] exp17_q[$];

    product_accumulate_module #(.N_SAMPLES(8), .ACC_W(20)) dut20 (
        .CLK(CLK), .RSTn(RSTn), .Clear_Sig(Clear_Sig), .Product(Product),
        .Product_Valid(Product_Valid), .Ack_Sig(Ack_Sig), .Sum(sum20),
        .Done_Sig(done20), .Sat_Sig(sat20), .Overrun_Sig(ovr20), .Count(cnt20),
        .dbg_state(dbg20)
    );

    product_accumulate_module #(.N_SAMPLES(8), .ACC_W(17)) dut17 (
        .CLK(CLK), .RSTn(RSTn), .Clear_Sig(Clear_Sig), .Product(Product),
        .Product_Valid(Product_Valid), .Ack_Sig(Ack_Sig), .Sum(sum17),
        .Done_Sig(done17), .Sat_Sig(sat17), .Overrun_Sig(ovr17), .Count(cnt17),
        .dbg_state(dbg17)
    );

    // ---------------- clock ----------------
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int s20, input bit st20, input int s17, input bit st17);
        exp20_q.push_back({st20, 20'(s20)});
        exp17_q.push_back({st17, 17'(s17)});
    endtask

    // One valid pulse followed by one idle cycle (multiply-stage cadence).
    task automatic send(input int p);
        Product       = 16'(p);
        Product_Valid = 1'b1;
        @(posedge CLK); #1;
        Product_Valid = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic send_n(input int p, input int n);
        for (int i = 0; i < n; i++) send(p);
    endtask

    task automatic ack;
        Ack_Sig = 1'b1;
        @(posedge CLK); #1;
        Ack_Sig = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic done20_prev = 1'b0;
    logic done17_prev = 1'b0;

    always @(negedge CLK) begin
        logic [20:0] e20;
        logic [17:0] e17;
        if (done20 && !done20_prev) begin
            if (exp20_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL batch20_unexpected: got sum 0x%0h with no expected batch", sum20);
            end else begin
                e20 = exp20_q.pop_front();
                check("batch20_sum", {12'b0, sum20}, {12'b0, e20[19:0]});
                check("batch20_sat", {31'b0, sat20}, {31'b0, e20[20]});
            end
        end
        if (done17 && !done17_prev) begin
            if (exp17_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL batch17_unexpected: got sum 0x%0h with no expected batch", sum17);
            end else begin
                e17 = exp17_q.pop_front();
                check("batch17_sum", {15'b0, sum17}, {15'b0, e17[16:0]});
                check("batch17_sat", {31'b0, sat17}, {31'b0, e17[17]});
            end
        end
        done20_prev <= done20;
        done17_prev <= done17;
    end

    // ---------------- stimulus ----------------
    initial begin
        RSTn          = 1'b0;
        Clear_Sig     = 1'b0;
        Product       = '0;
        Product_Valid = 1'b0;
        Ack_Sig       = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        check("reset_sum",   {12'b0, sum20}, 32'd0);
        check("reset_done",  {31'b0, done20}, 32'd0);
        check("reset_sat",   {31'b0, sat20}, 32'd0);
        check("reset_ovr",   {31'b0, ovr20}, 32'd0);
        check("reset_count", {24'b0, cnt20}, 32'd0);
        check("reset_state", {31'b0, dbg20}, 32'd0);
        RSTn = 1'b1;
        @(posedge CLK); #1;

        // Nominal batch
        push_exp(800, 1'b0, 800, 1'b0);
        send_n(100, 8);
        check("nominal_done",  {31'b0, done20}, 32'd1);
        check("nominal_count", {24'b0, cnt20}, 32'd0);
        check("nominal_state", {31'b0, dbg20}, 32'd1);
        ack;
        check("nominal_ack_done", {31'b0, done20}, 32'd0);

        // Signed mix
        push_exp(-800, 1'b0, -800, 1'b0);
        send_n(300, 4);
        send_n(-500, 4);
        ack;

        // Most negative products: fits in 20 bits, clamps in 17 bits
        push_exp(-262144, 1'b0, -65536, 1'b1);
        send_n(-32768, 8);
        ack;

        // Most positive products: fits in 20 bits, clamps in 17 bits
        push_exp(262136, 1'b0, 65535, 1'b1);
        send_n(32767, 8);
        ack;

        // Saturation flag must not carry into the next batch
        push_exp(8, 1'b0, 8, 1'b0);
        send_n(1, 8);

        // Overrun while DONE, then ack with a simultaneous product
        send(5);
        check("overrun_flag",   {31'b0, ovr20}, 32'd1);
        check("overrun_sum",    {12'b0, sum20}, 32'd8);
        check("overrun_count",  {24'b0, cnt20}, 32'd0);
        check("overrun_done",   {31'b0, done20}, 32'd1);
        check("overrun17_flag", {31'b0, ovr17}, 32'd1);
        push_exp(14, 1'b0, 14, 1'b0);
        Ack_Sig       = 1'b1;
        Product       = 16'sd7;
        Product_Valid = 1'b1;
        @(posedge CLK); #1;
        Ack_Sig       = 1'b0;
        Product_Valid = 1'b0;
        check("simul_done",  {31'b0, done20}, 32'd0);
        check("simul_count", {24'b0, cnt20}, 32'd1);
        check("simul_ovr",   {31'b0, ovr20}, 32'd1);
        @(posedge CLK); #1;
        send_n(1, 7);
        ack;

        // Clear mid-batch with a product on the same edge
        send_n(10, 3);
        check("pre_clear_count", {24'b0, cnt20}, 32'd3);
        Clear_Sig     = 1'b1;
        Product       = 16'sd1000;
        Product_Valid = 1'b1;
        @(posedge CLK); #1;
        Clear_Sig     = 1'b0;
        Product_Valid = 1'b0;
        check("clear_count", {24'b0, cnt20}, 32'd0);
        check("clear_ovr",   {31'b0, ovr20}, 32'd0);
        check("clear_done",  {31'b0, done20}, 32'd0);
        push_exp(16, 1'b0, 16, 1'b0);
        send_n(2, 8);
        check("post_clear_sum_held", {12'b0, sum20}, 32'd16);
        ack;

        // Asynchronous reset mid-batch
        send_n(50, 5);
        check("pre_reset_count", {24'b0, cnt20}, 32'd5);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_reset_sum",   {12'b0, sum20}, 32'd0);
        check("async_reset_count", {24'b0, cnt20}, 32'd0);
        check("async_reset_done",  {31'b0, done20}, 32'd0);
        check("async_reset_sat",   {31'b0, sat20}, 32'd0);
        check("async_reset_ovr",   {31'b0, ovr20}, 32'd0);
        @(posedge CLK); #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        push_exp(24, 1'b0, 24, 1'b0);
        send_n(3, 8);
        ack;

        // Drain: every queued batch must have been reported
        for (int i = 0; i < 50 && (exp20_q.size() != 0 || exp17_q.size() != 0); i++) begin
            @(posedge CLK);
        end
        #1;
        if (exp20_q.size() != 0 || exp17_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: got %0d/%0d batches outstanding expected 0",
                     exp20_q.size(), exp17_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
